get_abs_pos_state_machine: RTL and testbench

- Sequencer that time-shares one HLS absolute-position calculator between two motion axes.
- Per round: snapshots axis 1 operands onto the shared operand bus, starts the HLS core (ap_ctrl_hs style), captures its 64-bit result into the axis 1 result register, then repeats for axis 2.
- Sits between the per-axis encoder/config registers and the HLS core; results feed the register interface.

---
 rtl/get_abs_pos_pkg.sv | 19 +
 rtl/abs_pos_axis_select.sv | 38 +++
 rtl/get_abs_pos_state_machine.sv | 111 +++++++++++
 tb/tb_get_abs_pos_state_machine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/get_abs_pos_pkg.sv
// Shared types and default widths for the absolute-position sequencer.
// State encodings are visible on the state port, so they are fixed here.
package get_abs_pos_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int POS_W_DEF  = 64;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEL1      = 3'd1,
      START1    = 3'd2,
      WAIT1     = 3'd3,
      SEL2      = 3'd4,
      START2    = 3'd5,
      WAIT2     = 3'd6,
      ROUND_END = 3'd7
   } state_e;

endpackage

// File: rtl/abs_pos_axis_select.sv
// Registered 2:1 operand mux feeding the shared HLS core.
// The bus holds its value between loads, so operands stay stable while the core runs.
module abs_pos_axis_select #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              sel_axis2,
   input  logic [DATA_W-1:0] axis1_hw_counter,
   input  logic [DATA_W-1:0] axis1_set_position_part1,
   input  logic [DATA_W-1:0] axis1_set_position_part2,
   input  logic [DATA_W-1:0] axis1_counts_per_m,
   input  logic [DATA_W-1:0] axis2_hw_counter,
   input  logic [DATA_W-1:0] axis2_set_position_part1,
   input  logic [DATA_W-1:0] axis2_set_position_part2,
   input  logic [DATA_W-1:0] axis2_counts_per_m,
   output logic [DATA_W-1:0] selected_axis_hw_counter,
   output logic [DATA_W-1:0] selected_axis_set_position_part1,
   output logic [DATA_W-1:0] selected_axis_set_position_part2,
   output logic [DATA_W-1:0] selected_axis_counts_per_m
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         selected_axis_hw_counter         <= '0;
         selected_axis_set_position_part1 <= '0;
         selected_axis_set_position_part2 <= '0;
         selected_axis_counts_per_m       <= '0;
      end else if (load) begin
         selected_axis_hw_counter         <= sel_axis2 ? axis2_hw_counter         : axis1_hw_counter;
         selected_axis_set_position_part1 <= sel_axis2 ? axis2_set_position_part1 : axis1_set_position_part1;
         selected_axis_set_position_part2 <= sel_axis2 ? axis2_set_position_part2 : axis1_set_position_part2;
         selected_axis_counts_per_m       <= sel_axis2 ? axis2_counts_per_m       : axis1_counts_per_m;
      end
   end

endmodule

// File: rtl/get_abs_pos_state_machine.sv
// Time-shares one ap_ctrl_hs absolute-position core between two axes:
// select operands, start the core, capture its result, then repeat for axis 2.
module get_abs_pos_state_machine
   import get_abs_pos_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int POS_W  = POS_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_state_machine,
   input  logic              hls_done,
   input  logic              hls_ready,
   input  logic [DATA_W-1:0] axis1_hw_counter,
   input  logic [DATA_W-1:0] axis1_set_position_part1,
   input  logic [DATA_W-1:0] axis1_set_position_part2,
   input  logic [DATA_W-1:0] axis1_counts_per_m,
   input  logic [DATA_W-1:0] axis2_hw_counter,
   input  logic [DATA_W-1:0] axis2_set_position_part1,
   input  logic [DATA_W-1:0] axis2_set_position_part2,
   input  logic [DATA_W-1:0] axis2_counts_per_m,
   input  logic [POS_W-1:0]  selected_axis_hls_calculated_abs_pos,
   output logic              start_hls_calculations,
   output logic [2:0]        state,
   output logic [DATA_W-1:0] selected_axis_hw_counter,
   output logic [DATA_W-1:0] selected_axis_set_position_part1,
   output logic [DATA_W-1:0] selected_axis_set_position_part2,
   output logic [DATA_W-1:0] selected_axis_counts_per_m,
   output logic [POS_W-1:0]  axis1_hls_calculated_abs_pos,
   output logic [POS_W-1:0]  axis2_hls_calculated_abs_pos
);

   state_e state_q, state_d;
   logic   cap1, cap2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A done seen together with ready in STARTx skips the WAIT state.
   always_comb begin
      state_d = state_q;
      cap1    = 1'b0;
      cap2    = 1'b0;
      case (state_q)
         IDLE:   if (init_state_machine) state_d = SEL1;
         SEL1:   state_d = START1;
         START1: if (hls_ready) begin
                    if (hls_done) begin
                       cap1    = 1'b1;
                       state_d = SEL2;
                    end else begin
                       state_d = WAIT1;
                    end
                 end
         WAIT1:  if (hls_done) begin
                    cap1    = 1'b1;
                    state_d = SEL2;
                 end
         SEL2:   state_d = START2;
         START2: if (hls_ready) begin
                    if (hls_done) begin
                       cap2    = 1'b1;
                       state_d = ROUND_END;
                    end else begin
                       state_d = WAIT2;
                    end
                 end
         WAIT2:  if (hls_done) begin
                    cap2    = 1'b1;
                    state_d = ROUND_END;
                 end
         ROUND_END: state_d = init_state_machine ? SEL1 : IDLE;
         default:   state_d = IDLE;
      endcase
   end

   assign state                  = state_q;
   assign start_hls_calculations = (state_q == START1) || (state_q == START2);

   abs_pos_axis_select #(.DATA_W(DATA_W)) u_sel (
      .clk                              (clk),
      .rst                              (rst),
      .load                             ((state_q == SEL1) || (state_q == SEL2)),
      .sel_axis2                        (state_q == SEL2),
      .axis1_hw_counter                 (axis1_hw_counter),
      .axis1_set_position_part1         (axis1_set_position_part1),
      .axis1_set_position_part2         (axis1_set_position_part2),
      .axis1_counts_per_m               (axis1_counts_per_m),
      .axis2_hw_counter                 (axis2_hw_counter),
      .axis2_set_position_part1         (axis2_set_position_part1),
      .axis2_set_position_part2         (axis2_set_position_part2),
      .axis2_counts_per_m               (axis2_counts_per_m),
      .selected_axis_hw_counter         (selected_axis_hw_counter),
      .selected_axis_set_position_part1 (selected_axis_set_position_part1),
      .selected_axis_set_position_part2 (selected_axis_set_position_part2),
      .selected_axis_counts_per_m       (selected_axis_counts_per_m)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         axis1_hls_calculated_abs_pos <= '0;
         axis2_hls_calculated_abs_pos <= '0;
      end else begin
         if (cap1) axis1_hls_calculated_abs_pos <= selected_axis_hls_calculated_abs_pos;
         if (cap2) axis2_hls_calculated_abs_pos <= selected_axis_hls_calculated_abs_pos;
      end
   end

endmodule

// File: tb/tb_get_abs_pos_state_machine.sv
// Bench for the two-axis absolute-position sequencer: the expected trace of each
// round is derived from the HLS ready/done delays the bench itself plays back.
module tb_get_abs_pos_state_machine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init = 1'b0;
   logic        hls_done = 1'b0;
   logic        hls_ready = 1'b0;
   logic [63:0] hls_res = '0;
   logic [31:0] a1 [4];
   logic [31:0] a2 [4];
   logic        start;
   logic [2:0]  state;
   logic [31:0] bus [4];
   logic [63:0] r1, r2;

   logic [31:0] exp_bus [4];
   logic [31:0] snap [4];
   logic [63:0] exp_r1, exp_r2;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   get_abs_pos_state_machine dut (
      .clk                                  (clk),
      .rst                                  (rst),
      .init_state_machine                   (init),
      .hls_done                             (hls_done),
      .hls_ready                            (hls_ready),
      .axis1_hw_counter                     (a1[0]),
      .axis1_set_position_part1             (a1[1]),
      .axis1_set_position_part2             (a1[2]),
      .axis1_counts_per_m                   (a1[3]),
      .axis2_hw_counter                     (a2[0]),
      .axis2_set_position_part1             (a2[1]),
      .axis2_set_position_part2             (a2[2]),
      .axis2_counts_per_m                   (a2[3]),
      .selected_axis_hls_calculated_abs_pos (hls_res),
      .start_hls_calculations               (start),
      .state                                (state),
      .selected_axis_hw_counter             (bus[0]),
      .selected_axis_set_position_part1     (bus[1]),
      .selected_axis_set_position_part2     (bus[2]),
      .selected_axis_counts_per_m           (bus[3]),
      .axis1_hls_calculated_abs_pos         (r1),
      .axis2_hls_calculated_abs_pos         (r2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check(input logic [2:0] st, input logic st_on);
      chk("state", 64'(state), 64'(st));
      chk("start", 64'(start), 64'(st_on));
      for (int i = 0; i < 4; i++) chk($sformatf("bus%0d", i), 64'(bus[i]), 64'(exp_bus[i]));
      chk("axis1_result", r1, exp_r1);
      chk("axis2_result", r2, exp_r2);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic perturb();
      for (int i = 0; i < 4; i++) begin
         a1[i] = $urandom;
         a2[i] = $urandom;
      end
   endtask

   task automatic clear_expect();
      for (int i = 0; i < 4; i++) exp_bus[i] = '0;
      exp_r1 = '0;
      exp_r2 = '0;
   endtask

   task automatic idle_cycles(input int n);
      init = 1'b0;
      for (int i = 0; i < n; i++) begin
         hls_ready = 1'($urandom);
         hls_done  = 1'($urandom);
         hls_res   = {$urandom, $urandom};
         perturb();
         check(3'd0, 1'b0);
         tick();
      end
      hls_ready = 1'b0;
      hls_done  = 1'b0;
   endtask

   // One axis: SEL for 1 cycle, START for rd+1 cycles (ready on the last),
   // then dd WAIT cycles (done on the last); dd=0 means done arrives with ready.
   task automatic run_axis(input int ax, input int rd, input int dd, input logic [63:0] res,
                           input bit rnd, input bit hold);
      logic [2:0] base;
      logic       fire;
      base = (ax == 1) ? 3'd1 : 3'd4;
      check(base, 1'b0);
      for (int i = 0; i < 4; i++) snap[i] = (ax == 1) ? a1[i] : a2[i];
      tick();
      for (int i = 0; i < 4; i++) exp_bus[i] = snap[i];
      for (int k = 0; k <= rd; k++) begin
         check(base + 3'd1, 1'b1);
         fire      = (k == rd) && (dd == 0);
         hls_ready = (k == rd);
         hls_done  = fire;
         hls_res   = fire ? res : {$urandom, $urandom};
         if (rnd) perturb();
         tick();
         if (fire) begin
            if (ax == 1) exp_r1 = res; else exp_r2 = res;
         end
      end
      for (int k = 1; k <= dd; k++) begin
         check(base + 3'd2, 1'b0);
         fire      = (k == dd);
         hls_ready = rnd ? 1'($urandom) : 1'b0;
         hls_done  = fire;
         hls_res   = fire ? res : {$urandom, $urandom};
         if (rnd) perturb();
         if (hold && ax == 1 && k == 1) a1[0] = 32'h999;
         tick();
         if (fire) begin
            if (ax == 1) exp_r1 = res; else exp_r2 = res;
         end
      end
      hls_ready = 1'b0;
      hls_done  = 1'b0;
   endtask

   task automatic run_round(input int rd1, input int dd1, input logic [63:0] res1,
                            input int rd2, input int dd2, input logic [63:0] res2,
                            input bit init_after, input bit rnd, input bit hold);
      run_axis(1, rd1, dd1, res1, rnd, hold);
      run_axis(2, rd2, dd2, res2, rnd, 1'b0);
      init = init_after;
      check(3'd7, 1'b0);
      tick();
      if (!init_after) check(3'd0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         a1[i] = '0;
         a2[i] = '0;
      end
      clear_expect();

      // reset held with random inputs
      for (int i = 0; i < 10; i++) begin
         perturb();
         init      = 1'($urandom);
         hls_ready = 1'($urandom);
         hls_done  = 1'($urandom);
         hls_res   = {$urandom, $urandom};
         tick();
         check(3'd0, 1'b0);
      end
      rst = 1'b0;
      idle_cycles(10);

      // directed round: ready 2 cycles after start, done 3 cycles later
      a1[0] = 32'h100; a1[1] = 32'h1; a1[2] = 32'h2; a1[3] = 32'h3E8;
      a2[0] = 32'h200; a2[1] = 32'h4; a2[2] = 32'h5; a2[3] = 32'h7D0;
      init = 1'b1;
      tick();
      init = 1'b0;
      run_round(2, 3, 64'h0000_0001_0000_0100, 2, 3, 64'h0000_0002_0000_0200, 1'b0, 1'b0, 1'b1);
      chk("axis1_final", r1, 64'h0000_0001_0000_0100);
      chk("axis2_final", r2, 64'h0000_0002_0000_0200);
      chk("bus_after_round", 64'(bus[0]), 64'h200);
      idle_cycles(3);

      // operand pick-up on the next round sees the changed input
      init = 1'b1;
      tick();
      init = 1'b0;
      run_round(0, 0, {$urandom, $urandom}, 0, 0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
      idle_cycles(2);

      // minimum-length round with random operands
      init = 1'b1;
      tick();
      init = 1'b0;
      run_round(0, 0, {$urandom, $urandom}, 0, 0, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
      idle_cycles(2);

      // continuous mode, results incrementing per round
      init = 1'b1;
      tick();
      for (int rnd_i = 1; rnd_i <= 3; rnd_i++)
         run_round($urandom_range(0, 3), $urandom_range(0, 3), 64'(rnd_i) + 64'h1000,
                   $urandom_range(0, 3), $urandom_range(0, 3), 64'(rnd_i) + 64'h2000,
                   rnd_i < 3, 1'b1, 1'b0);
      chk("cont_axis1", r1, 64'h1003);
      chk("cont_axis2", r2, 64'h2003);
      idle_cycles(2);

      // long stall waiting for ready in START2
      init = 1'b1;
      tick();
      init = 1'b0;
      run_round(1, 1, {$urandom, $urandom}, 50, 2, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
      idle_cycles(2);

      // random rounds
      for (int j = 0; j < 5; j++) begin
         init = 1'b1;
         tick();
         init = 1'($urandom);
         run_round($urandom_range(0, 4), $urandom_range(0, 4), {$urandom, $urandom},
                   $urandom_range(0, 4), $urandom_range(0, 4), {$urandom, $urandom},
                   1'b0, 1'b1, 1'b0);
         idle_cycles($urandom_range(1, 3));
      end

      // reset asserted mid-WAIT1, with done pending: nothing may be captured
      init = 1'b1;
      tick();
      init = 1'b0;
      check(3'd1, 1'b0);
      for (int i = 0; i < 4; i++) snap[i] = a1[i];
      tick();
      for (int i = 0; i < 4; i++) exp_bus[i] = snap[i];
      check(3'd2, 1'b1);
      hls_ready = 1'b1;
      tick();
      hls_ready = 1'b0;
      check(3'd3, 1'b0);
      hls_done = 1'b1;
      hls_res  = {$urandom, $urandom};
      rst = 1'b1;
      #1;
      clear_expect();
      check(3'd0, 1'b0);
      tick();
      check(3'd0, 1'b0);
      hls_done = 1'b0;
      rst = 1'b0;
      idle_cycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
